packer_seq_ctrl: RTL and testbench
==================================

# packer_seq_ctrl

Transaction sequencer that sits in front of the 64-bit receive packer and drives its data, done, error and flush inputs. Per transfer it takes a length in 32-bit words, forwards exactly that many words from the receive datapath, and marks the end of the packet. It then issues a flush, waits for the packer's flushed acknowledgement, and reports completion or error to the channel logic.

## Interface
- C_LEN_WIDTH, default 32: width of transfer length and word counter, in 32-bit words.

- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- XFER_START  in  1  one-cycle request; starts a transfer of XFER_LEN words. Honoured only in IDLE.
- XFER_LEN  in  C_LEN_WIDTH  expected 32-bit word count; sampled with XFER_START.
- XFER_ABORT  in  1  terminates the current transfer with error.
- RX_DATA  in  64  receive data; low word first.
- RX_DATA_EN  in  2  valid word count in RX_DATA: 0, 1 (low word) or 2. Value 3 is treated as 2.
- RX_DATA_ERR  in  1  upstream error on this cycle.
- PK_DATA  out  64  registered RX_DATA, to packer data input.
- PK_DATA_EN  out  2  registered and possibly truncated word enable, to packer.
- PK_DONE  out  1  end-of-packet strobe, to packer.
- PK_ERR  out  1  error strobe, to packer.
- PK_FLUSH  out  1  flush strobe, to packer.
- PK_FLUSHED  in  1  flush-complete strobe from packer.
- XFER_BUSY  out  1  high from the cycle after an accepted start until return to IDLE.
- XFER_DONE  out  1  one-cycle completion pulse.
- XFER_ERR  out  1  sticky error flag; cleared by the next accepted XFER_START.
- XFER_COUNT  out  C_LEN_WIDTH  words forwarded in the current or last transfer.

## Operation
- States:
  - IDLE, RECV, DONE, FLUSH, WAIT.
  - State is registered. PK_DONE = (state==DONE); PK_FLUSH = (state==FLUSH).
- IDLE:
  - RX_DATA_EN is ignored and PK_DATA_EN is 0.
  - XFER_START: latch XFER_LEN, clear XFER_COUNT and XFER_ERR.
  - Next state is RECV, or DONE if XFER_LEN==0.
- RECV:
  - With remaining = len − count, forwarded words = min(EN, remaining).
  - If EN exceeds remaining: set XFER_ERR (overrun), and drop the excess words (high word first).
  - count += forwarded words.
  - When count reaches len, next state is DONE.
- Error in RECV (XFER_ABORT or RX_DATA_ERR):
  - Data on the same cycle is still forwarded.
  - PK_ERR pulses on the next cycle, coincident with the DONE state.
  - XFER_ERR is set.
  - Next state is DONE regardless of count.
  - Error wins over a simultaneous final word.
- DONE: one cycle, then FLUSH.
- FLUSH: one cycle, then WAIT.
- WAIT:
  - On PK_FLUSHED: XFER_DONE pulses on the next cycle and state returns to IDLE.
  - XFER_ABORT in DONE, FLUSH or WAIT is ignored.
- Any words arriving outside RECV are dropped silently; no error is flagged.
- XFER_START outside IDLE is ignored.
- Reset mid-transfer:
  - State goes to IDLE immediately.
  - All outputs go to 0.
  - No flush is issued.

## Timing
- Reset values: every output is 0; the latched length is 0.
- Data latency: RX_* at cycle T appears on PK_DATA/PK_DATA_EN at T+1.
- Start: XFER_START at cycle S gives XFER_BUSY=1 and state RECV at S+1, so the first word is accepted at S+1.
- End of packet: if the final word arrives at T, then at T+1 both PK_DATA_EN (final) and PK_DONE are high.
- Flush sequence: PK_FLUSH at T+2.
- Completion (packer returns PK_FLUSHED two cycles after sampling PK_FLUSH):
  - PK_FLUSHED at T+4, XFER_DONE at T+5.
  - XFER_BUSY falls at T+5.
  - Earliest next accepted start is at T+5.
- Zero-length transfer: START at S, then PK_DONE at S+1, PK_FLUSH at S+2, XFER_DONE at S+5.

## Configuration
- PACKER_SEQ_TIMEOUT_EN
  - Defined: an 8-bit counter runs in WAIT, cleared on entry. After 255 WAIT cycles without PK_FLUSHED, XFER_ERR is set, XFER_DONE pulses and state returns to IDLE.
  - Undefined: no counter; WAIT holds until PK_FLUSHED or reset.

## Test plan
- Even length: LEN=4, EN=2 on two consecutive cycles → PK_DATA_EN=2,2; PK_DONE with second; PK_FLUSH next; XFER_DONE 3 cycles after PK_FLUSH; XFER_COUNT=4; XFER_ERR=0.
- Odd length with overrun: LEN=3, EN=2,2 → PK_DATA_EN=2,1; XFER_COUNT=3; XFER_ERR=1; dropped word never reaches packer.
- Zero length and late data: LEN=0 → no PK_DATA_EN; PK_DONE at S+1, XFER_DONE at S+5. EN=2 presented in DONE/FLUSH is dropped and XFER_COUNT stays 0.
- Abort mid-RECV: LEN=10, abort after 4 words, with EN=2 on the abort cycle → 6 words forwarded; PK_ERR and PK_DONE coincide; flush sequence completes; XFER_ERR=1. Next START clears XFER_ERR.
- Busy and reset behaviour: START while BUSY is ignored (length unchanged). RST_N low during WAIT → all outputs 0 immediately, state IDLE, no PK_FLUSH afterwards.
- Timeout (PACKER_SEQ_TIMEOUT_EN defined): PK_FLUSHED held low → XFER_ERR=1 and XFER_DONE pulse 255 cycles after WAIT entry. With the macro undefined, BUSY stays high indefinitely.

Source files
------------

// File: rtl/packer_seq_ctrl.sv
// Transaction sequencer driving the 64-bit receive packer: forwards a fixed
// word count, marks end of packet, flushes. Optional WAIT timeout: PACKER_SEQ_TIMEOUT_EN.
`default_nettype none

module packer_seq_ctrl #(
  parameter int unsigned C_LEN_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   XFER_START,
  input  logic [C_LEN_WIDTH-1:0] XFER_LEN,
  input  logic                   XFER_ABORT,
  input  logic [63:0]            RX_DATA,
  input  logic [1:0]             RX_DATA_EN,
  input  logic                   RX_DATA_ERR,
  output logic [63:0]            PK_DATA,
  output logic [1:0]             PK_DATA_EN,
  output logic                   PK_DONE,
  output logic                   PK_ERR,
  output logic                   PK_FLUSH,
  input  logic                   PK_FLUSHED,
  output logic                   XFER_BUSY,
  output logic                   XFER_DONE,
  output logic                   XFER_ERR,
  output logic [C_LEN_WIDTH-1:0] XFER_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_DONE,
    S_FLUSH,
    S_WAIT
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [C_LEN_WIDTH-1:0] len_q;
  logic [C_LEN_WIDTH-1:0] remaining;
  logic [C_LEN_WIDTH-1:0] count_nxt;
  logic [1:0]             en_eff;
  logic [1:0]             fwd;
  logic                   overrun;
  logic                   rx_fault;
  logic                   start_ok;
  logic                   timeout;

  // Word accounting: forwarded = min(enable, remaining); excess is an overrun.
  always_comb begin
    en_eff    = (RX_DATA_EN == 2'd3) ? 2'd2 : RX_DATA_EN;
    remaining = len_q - XFER_COUNT;
    overrun   = 1'b0;
    fwd       = '0;
    rx_fault  = 1'b0;
    if (state == S_RECV) begin
      overrun  = C_LEN_WIDTH'(en_eff) > remaining;
      fwd      = overrun ? remaining[1:0] : en_eff;
      rx_fault = XFER_ABORT || RX_DATA_ERR;
    end
    count_nxt = XFER_COUNT + C_LEN_WIDTH'(fwd);
    start_ok  = (state == S_IDLE) && XFER_START;
  end

`ifdef PACKER_SEQ_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counter sits at zero outside WAIT, so the first WAIT cycle sees zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    timeout = (state == S_WAIT) && !PK_FLUSHED && (wait_cnt == 8'd254);
  end
`else
  always_comb begin
    timeout = 1'b0;
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    PK_DONE   = 1'b0;
    PK_FLUSH  = 1'b0;
    XFER_BUSY = 1'b0;
    case (state)
      S_IDLE: begin
        if (XFER_START) begin
          state_nxt = (XFER_LEN == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        XFER_BUSY = 1'b1;
        if (rx_fault || (count_nxt == len_q)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        XFER_BUSY = 1'b1;
        PK_DONE   = 1'b1;
        state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        XFER_BUSY = 1'b1;
        PK_FLUSH  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        XFER_BUSY = 1'b1;
        if (PK_FLUSHED || timeout) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PK_DATA    <= '0;
      PK_DATA_EN <= '0;
      PK_ERR     <= 1'b0;
      XFER_DONE  <= 1'b0;
      XFER_ERR   <= 1'b0;
      XFER_COUNT <= '0;
      len_q      <= '0;
    end else begin
      PK_DATA    <= RX_DATA;
      PK_DATA_EN <= fwd;
      PK_ERR     <= rx_fault;
      XFER_DONE  <= (state == S_WAIT) && (PK_FLUSHED || timeout);
      if (start_ok) begin
        len_q      <= XFER_LEN;
        XFER_COUNT <= '0;
        XFER_ERR   <= 1'b0;
      end else if (state == S_RECV) begin
        XFER_COUNT <= count_nxt;
        if (overrun || rx_fault) begin
          XFER_ERR <= 1'b1;
        end
      end else if (timeout) begin
        XFER_ERR <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_packer_seq_ctrl.sv
// Randomized self-checking bench for packer_seq_ctrl; a transaction-level model
// predicts forwarded words, final count/error and the packet/flush timeline.
module tb_packer_seq_ctrl;

  localparam int unsigned LW = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          XFER_START = 1'b0;
  logic [LW-1:0] XFER_LEN = '0;
  logic          XFER_ABORT = 1'b0;
  logic [63:0]   RX_DATA = '0;
  logic [1:0]    RX_DATA_EN = '0;
  logic          RX_DATA_ERR = 1'b0;
  logic [63:0]   PK_DATA;
  logic [1:0]    PK_DATA_EN;
  logic          PK_DONE;
  logic          PK_ERR;
  logic          PK_FLUSH;
  logic          PK_FLUSHED = 1'b0;
  logic          XFER_BUSY;
  logic          XFER_DONE;
  logic          XFER_ERR;
  logic [LW-1:0] XFER_COUNT;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int          flush_cnt = 0;
  int          flush_delay = 2;
  bit          flush_en = 1'b1;

  packer_seq_ctrl #(.C_LEN_WIDTH(LW)) dut (
    .CLK(CLK), .RST_N(RST_N), .XFER_START(XFER_START), .XFER_LEN(XFER_LEN),
    .XFER_ABORT(XFER_ABORT), .RX_DATA(RX_DATA), .RX_DATA_EN(RX_DATA_EN),
    .RX_DATA_ERR(RX_DATA_ERR), .PK_DATA(PK_DATA), .PK_DATA_EN(PK_DATA_EN),
    .PK_DONE(PK_DONE), .PK_ERR(PK_ERR), .PK_FLUSH(PK_FLUSH), .PK_FLUSHED(PK_FLUSHED),
    .XFER_BUSY(XFER_BUSY), .XFER_DONE(XFER_DONE), .XFER_ERR(XFER_ERR),
    .XFER_COUNT(XFER_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance to the next falling edge and play the packer's flush handshake.
  task automatic tick();
    @(negedge CLK);
    PK_FLUSHED = 1'b0;
    if (flush_cnt > 0) begin
      flush_cnt--;
      if (flush_cnt == 0) PK_FLUSHED = 1'b1;
    end
    if (PK_FLUSH && flush_en) flush_cnt = flush_delay;
  endtask

  // Cycle 0 drives the start; outputs of cycle j are sampled at its falling edge.
  task automatic run_xfer(input int unsigned len, input int unsigned force_en,
                          input int unsigned fault_at, input bit fault_kind,
                          input int unsigned extra);
    logic [1:0]  en_q[$];
    logic [63:0] dat_q[$];
    int unsigned fwd_q[$];
    int unsigned cnt, k, eff, left, fwd, last, words_seen, exp_en;
    bit          err, faulted;
    logic [1:0]  en;
    logic [63:0] d;
    cnt = 0; k = 0; err = 1'b0; faulted = 1'b0; words_seen = 0;
    while (cnt < len && !faulted) begin
      k++;
      if (force_en != 0) en = 2'(force_en);
      else if (k > 40) en = 2'd2;
      else en = 2'($urandom_range(3));
      d = {$urandom, $urandom};
      eff = (en == 2'd3) ? 2 : int'(en);
      left = len - cnt;
      fwd = (eff > left) ? left : eff;
      if (eff > left) err = 1'b1;
      cnt += fwd;
      if (k == fault_at) begin
        faulted = 1'b1;
        err = 1'b1;
      end
      en_q.push_back(en);
      dat_q.push_back(d);
      fwd_q.push_back(fwd);
    end
    last = k + 5 + extra;
    flush_delay = 2 + int'(extra);

    XFER_START = 1'b1; XFER_LEN = len; RX_DATA_EN = 2'd2;
    RX_DATA = {$urandom, $urandom}; XFER_ABORT = 1'b0; RX_DATA_ERR = 1'b0;
    for (int unsigned j = 1; j <= last; j++) begin
      tick();
      exp_en = (j >= 2 && j <= k + 1) ? fwd_q[j-2] : 0;
      check("pk_data_en", PK_DATA_EN, exp_en);
      if (exp_en >= 1) begin
        d = dat_q[j-2];
        check("pk_data_lo", PK_DATA[31:0], d[31:0]);
        if (exp_en == 2) check("pk_data_hi", PK_DATA[63:32], d[63:32]);
      end
      words_seen += PK_DATA_EN;
      check("pk_done", PK_DONE, j == k + 1);
      check("pk_err", PK_ERR, faulted && (j == k + 1));
      check("pk_flush", PK_FLUSH, j == k + 2);
      check("xfer_done", XFER_DONE, j == last);
      check("xfer_busy", XFER_BUSY, j < last);
      if (j == 1) begin
        check("count_cleared", XFER_COUNT, 0);
        check("err_cleared", XFER_ERR, 0);
      end
      if (j == last) begin
        check("xfer_count", XFER_COUNT, cnt);
        check("xfer_err", XFER_ERR, err);
        check("words_to_packer", words_seen, cnt);
      end
      XFER_START = 1'b0; XFER_ABORT = 1'b0; RX_DATA_ERR = 1'b0;
      RX_DATA = {$urandom, $urandom};
      if (j <= k) begin
        RX_DATA_EN = en_q[j-1];
        RX_DATA = dat_q[j-1];
        if (j == fault_at) begin
          XFER_ABORT = !fault_kind;
          RX_DATA_ERR = fault_kind;
        end
      end else begin
        RX_DATA_EN = 2'($urandom_range(3));
        if (j < last) begin
          XFER_ABORT = 1'($urandom_range(1));
          RX_DATA_ERR = 1'($urandom_range(1));
        end
      end
      if (j < last && $urandom_range(3) == 0) begin
        XFER_START = 1'b1;
        XFER_LEN = $urandom_range(50);
      end
    end
  endtask

  initial begin
    int unsigned len, fa;
    bit ok;
    int unsigned seen;
    repeat (3) tick();
    check("rst_pk_data", PK_DATA, 0);
    check("rst_pk_data_en", PK_DATA_EN, 0);
    check("rst_strobes", {PK_DONE, PK_ERR, PK_FLUSH}, 0);
    check("rst_xfer", {XFER_BUSY, XFER_DONE, XFER_ERR}, 0);
    check("rst_count", XFER_COUNT, 0);
    RST_N = 1'b1;
    tick();

    run_xfer(4, 2, 0, 1'b0, 0);
    run_xfer(3, 2, 0, 1'b0, 0);
    run_xfer(0, 0, 0, 1'b0, 0);
    run_xfer(10, 2, 3, 1'b0, 0);
    run_xfer(5, 0, 0, 1'b0, 1);
    run_xfer(7, 3, 2, 1'b1, 0);
    for (int i = 0; i < 30; i++) begin
      len = $urandom_range(12);
      fa = ($urandom_range(3) == 0) ? $urandom_range(len + 1, 1) : 0;
      run_xfer(len, 0, fa, 1'($urandom_range(1)), $urandom_range(2));
    end

    // Reset while waiting for the flush acknowledgement.
    flush_en = 1'b0;
    XFER_START = 1'b1; XFER_LEN = 2; RX_DATA_EN = 2'd0;
    tick();
    XFER_START = 1'b0; RX_DATA_EN = 2'd2;
    tick();
    RX_DATA_EN = 2'd0;
    tick();
    tick();
    check("busy_in_wait", XFER_BUSY, 1);
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_pk", {PK_DATA, PK_DATA_EN, PK_DONE, PK_ERR, PK_FLUSH} == '0, 1);
    check("async_rst_xfer", {XFER_BUSY, XFER_DONE, XFER_ERR, XFER_COUNT} == '0, 1);
    tick();
    RST_N = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      tick();
      if (PK_FLUSH || XFER_BUSY || XFER_DONE) ok = 1'b0;
    end
    check("no_flush_after_rst", ok, 1);

    // Packer never acknowledges the flush.
    XFER_START = 1'b1; XFER_LEN = 1;
    tick();
    XFER_START = 1'b0; RX_DATA_EN = 2'd1;
    tick();
    RX_DATA_EN = 2'd0;
    tick();
    tick();
`ifdef PACKER_SEQ_TIMEOUT_EN
    seen = 0;
    for (int unsigned j = 5; j <= 400; j++) begin
      tick();
      if (XFER_DONE && seen == 0) begin
        seen = j;
        check("timeout_err", XFER_ERR, 1);
      end
    end
    check("timeout_cycle", seen, 259);
`else
    ok = 1'b1;
    repeat (300) begin
      tick();
      if (!XFER_BUSY || XFER_DONE) ok = 1'b0;
    end
    check("wait_holds_busy", ok, 1);
    seen = 0;
`endif
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    flush_en = 1'b1;
    flush_cnt = 0;
    tick();
    run_xfer(6, 0, 0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
